ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port, registered-read RAM (1-cycle read latency, tri-stated read data unless read-enabled and not writing) between two requesters: A (core data port) and B (loader/debug port).
- Per-port valid/ready request handshake with a response pulse for reads.
- Round-robin arbitration.
- Back-to-back reads are pipelined at one per cycle.
- Sits between the requesters and the RAM instance and drives all RAM control.

Parameters:
- ADDR_WIDTH, 32, width of the request address and the RAM address.
- DATA_WIDTH, 32, width of the write data, read data and RAM data.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rstN  in  1  synchronous active-low reset
- aValid  in  1  port A request valid
- aReady  out  1  port A request accepted this cycle (grant)
- aWrite  in  1  1 = write, 0 = read
- aAddr  in  ADDR_WIDTH  port A address
- aWData  in  DATA_WIDTH  port A write data
- aRspValid  out  1  port A read data valid (1-cycle pulse)
- bValid, bReady, bWrite, bAddr, bWData, bRspValid  as port A, for port B
- rspData  out  DATA_WIDTH  read data, shared by both ports; qualified by aRspValid/bRspValid
- ramAddress  out  ADDR_WIDTH  to RAM address
- ramWriteData  out  DATA_WIDTH  to RAM write data
- ramWriteEnable  out  1  to RAM write enable
- ramReadEnable  out  1  to RAM read enable
- ramReadData  in  DATA_WIDTH  from RAM read data

Behaviour:
- Reset (rstN low at a clock edge):
  - State goes to IDLE; lastGrant = B, so A wins the first conflict; rspOwner cleared.
  - aRspValid/bRspValid = 0.
  - While rstN is low, aReady/bReady/ramWriteEnable/ramReadEnable are forced to 0.
  - ramAddress/ramWriteData are 0 while reset is active.
  - A read outstanding at reset is dropped; no response is produced.
- Transfer rule: a request is accepted on a clock edge where xValid & xReady are both high.
  - xReady is combinational from the valids and the state.
  - Requester inputs must stay stable while xValid is high and xReady is low.
- Arbitration:
  - Only one valid: that port is granted, if eligible.
  - Both valid: the port not equal to lastGrant is granted.
  - lastGrant is updated on every accepted transfer.
- RAM drive:
  - The granted port's address and data drive ramAddress/ramWriteData.
  - A granted write sets ramWriteEnable = 1; a granted read sets ramReadEnable = 1.
  - No grant: ramWriteEnable = 0, ramReadEnable = 0; ramAddress holds its last value.
- States:
  - IDLE: reads and writes are eligible.
    - Accepted write → stays IDLE. The write completes at that edge; no response.
    - Accepted read → RESP, with rspOwner = granted port.
  - RESP: ramReadEnable is held at 1 and ramWriteEnable at 0, so RAM read data is driven.
    - rspData = ramReadData; the owner's RspValid = 1 for this cycle.
    - Only reads are eligible; writes see xReady = 0 (a write would tri-state the data in flight).
    - Accepted read in RESP → stays RESP with the new owner; the new address is presented this cycle. This gives 1 read per cycle.
    - No accepted read → IDLE.
- Latency:
  - Write: accepted and complete in the same cycle.
  - Read: data valid in the cycle after acceptance.
- rspData outside a response cycle is don't-care (driven 0). The block never passes high-Z to the requesters.

Optional Feature:
- Macro RAM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins when both ports are valid and eligible; lastGrant is unused. Port B can starve; this is intended for the core-has-priority configuration.
- Undefined: round-robin as above.

Decomposition:
- Shared package/header holds:
  - State encoding constants: ST_IDLE = 1'b0, ST_RESP = 1'b1.
  - Port-ID constants: PORT_A = 1'b0, PORT_B = 1'b1.
- One natural sub-module: rr_arbiter2 (2-way grant logic with the lastGrant register and the fixed-priority macro hook).

Test Plan:
- Reset 3 cycles, then release with no requests → all readies, RAM enables and RspValids are 0.
- A writes 0xDEADBEEF to address 0x10, then A reads 0x10 → aReady same cycle as each request; aRspValid exactly 1 cycle after the read is accepted with rspData = 0xDEADBEEF.
- A and B both read continuously (addresses 0x1 and 0x2, preloaded 0x11 and 0x22) → grants alternate A, B, A, B; one RspValid every cycle with the matching data. With RAM_ARB_FIXED_PRIO_EN defined, A is granted every cycle and B never.
- A read at 0x5, with B write pending in the next cycle → bReady = 0 during RESP; B is accepted the cycle after, in IDLE; the read data is unaffected.
- Reset asserted in RESP after an accepted read → no RspValid is produced; the block is IDLE after release.
- Read at address 0x3FF (top of a 1024-entry RAM) followed by a write to 0x0 → correct data returned, then the write lands; no aliasing.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: state and port-ID encodings shared by ram_arbiter and rr_arbiter2.
// Build option RAM_ARB_FIXED_PRIO_EN selects fixed A-priority arbitration in rr_arbiter2.
package ram_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_RESP = 1'b1} state_e;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// rr_arbiter2: 2-way grant logic; round-robin on lastGrant, or A-priority with RAM_ARB_FIXED_PRIO_EN.
// Requests must already be qualified by eligibility; every grant counts as an accepted transfer.
module rr_arbiter2 import ram_arbiter_pkg::*; (
  input  logic clk,
  input  logic rstN,
  input  logic a_req_i,
  input  logic b_req_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);
`ifdef RAM_ARB_FIXED_PRIO_EN
  assign b_gnt_o = b_req_i & !a_req_i;
`else
  logic last_q, last_d;
  // On a conflict, the port that did not win last time wins now.
  assign b_gnt_o = b_req_i & (!a_req_i | last_q == PORT_A);
  assign last_d = a_gnt_o ? PORT_A : b_gnt_o ? PORT_B : last_q;
  always_ff @(posedge clk)
    last_q <= !rstN ? PORT_B : last_d;
`endif
  assign a_gnt_o = a_req_i & !b_gnt_o;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered-read single-port RAM between ports A and B with pipelined reads.
// Define RAM_ARB_FIXED_PRIO_EN to give port A fixed priority instead of round-robin.
module ram_arbiter import ram_arbiter_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  aValid,
  output logic                  aReady,
  input  logic                  aWrite,
  input  logic [ADDR_WIDTH-1:0] aAddr,
  input  logic [DATA_WIDTH-1:0] aWData,
  output logic                  aRspValid,
  input  logic                  bValid,
  output logic                  bReady,
  input  logic                  bWrite,
  input  logic [ADDR_WIDTH-1:0] bAddr,
  input  logic [DATA_WIDTH-1:0] bWData,
  output logic                  bRspValid,
  output logic [DATA_WIDTH-1:0] rspData,
  output logic [ADDR_WIDTH-1:0] ramAddress,
  output logic [DATA_WIDTH-1:0] ramWriteData,
  output logic                  ramWriteEnable,
  output logic                  ramReadEnable,
  input  logic [DATA_WIDTH-1:0] ramReadData
);
  state_e state_q, state_d;
  logic owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic a_req, b_req, a_gnt, b_gnt, gnt, gnt_write, gnt_read, in_resp;
  assign in_resp = rstN & (state_q == ST_RESP);
  // A write during RESP would turn the RAM data bus around while read data is in flight.
  assign a_req = rstN & aValid & (state_q == ST_IDLE | !aWrite);
  assign b_req = rstN & bValid & (state_q == ST_IDLE | !bWrite);
  rr_arbiter2 u_arb (
    .clk     (clk),
    .rstN    (rstN),
    .a_req_i (a_req),
    .b_req_i (b_req),
    .a_gnt_o (a_gnt),
    .b_gnt_o (b_gnt)
  );
  assign gnt = a_gnt | b_gnt;
  assign gnt_write = b_gnt ? bWrite : aWrite;
  assign gnt_read = gnt & !gnt_write;
  assign aReady = a_gnt;
  assign bReady = b_gnt;
  assign ramWriteEnable = gnt & gnt_write;
  assign ramReadEnable = gnt_read | in_resp;
  assign ramAddress = !rstN ? '0 : b_gnt ? bAddr : a_gnt ? aAddr : addr_q;
  assign ramWriteData = !rstN ? '0 : b_gnt ? bWData : a_gnt ? aWData : wdata_q;
  assign aRspValid = in_resp & owner_q == PORT_A;
  assign bRspValid = in_resp & owner_q == PORT_B;
  assign rspData = in_resp ? ramReadData : '0;
  always_comb begin
    state_d = ST_IDLE;
    owner_d = owner_q;
    state_d = gnt_read ? ST_RESP : ST_IDLE;
    owner_d = gnt_read ? (b_gnt ? PORT_B : PORT_A) : owner_q;
  end
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_A;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= ramAddress;
      wdata_q <= ramWriteData;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table, reset corner cases and random traffic against a transaction-level model.
// Honours RAM_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_ram_arbiter;
  logic clk = 0, rstN = 0;
  logic aValid = 0, aWrite = 0, bValid = 0, bWrite = 0;
  logic [31:0] aAddr = 0, aWData = 0, bAddr = 0, bWData = 0;
  logic aReady, bReady, aRspValid, bRspValid, ramWriteEnable, ramReadEnable;
  logic [31:0] rspData, ramAddress, ramWriteData;
  wire  [31:0] ramReadData;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rstN(rstN),
    .aValid(aValid), .aReady(aReady), .aWrite(aWrite), .aAddr(aAddr), .aWData(aWData), .aRspValid(aRspValid),
    .bValid(bValid), .bReady(bReady), .bWrite(bWrite), .bAddr(bAddr), .bWData(bWData), .bRspValid(bRspValid),
    .rspData(rspData), .ramAddress(ramAddress), .ramWriteData(ramWriteData),
    .ramWriteEnable(ramWriteEnable), .ramReadEnable(ramReadEnable), .ramReadData(ramReadData)
  );

  // 1024-entry registered-read RAM, output tri-stated unless reading
  logic [31:0] ram_mem [1024];
  logic [31:0] ram_q;
  always @(posedge clk) begin
    if (ramWriteEnable) ram_mem[ramAddress[9:0]] <= ramWriteData;
    if (ramReadEnable && !ramWriteEnable) ram_q <= ram_mem[ramAddress[9:0]];
  end
  assign ramReadData = (ramReadEnable && !ramWriteEnable) ? ram_q : 32'hzzzz_zzzz;

  // transaction-level reference: memory image, the response due next cycle, last winner
  logic [31:0] ref_mem [1024];
  bit pend_v = 0;
  logic pend_b = 0, last_b = 1;
  logic [31:0] pend_d = 0, ref_addr = 0, ref_wd = 0;
  bit m_ga = 0, m_gb = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input bit use_tbl = 0, input logic [3:0] ef = 0, input logic [31:0] ed = 0);
    bit rsp, ae, be, ga, gb, gw;
    logic [31:0] eaddr, ewd;
    @(negedge clk);
    rsp = rstN && pend_v;
    ae = rstN && aValid && (!pend_v || !aWrite);
    be = rstN && bValid && (!pend_v || !bWrite);
`ifdef RAM_ARB_FIXED_PRIO_EN
    gb = be && !ae;
`else
    gb = be && (!ae || !last_b);
`endif
    ga = ae && !gb;
    gw = gb ? bWrite : aWrite;
    eaddr = !rstN ? 0 : gb ? bAddr : ga ? aAddr : ref_addr;
    ewd = !rstN ? 0 : gb ? bWData : ga ? aWData : ref_wd;
    chk("aReady", 32'(aReady), 32'(ga));
    chk("bReady", 32'(bReady), 32'(gb));
    chk("ramWriteEnable", 32'(ramWriteEnable), 32'((ga || gb) && gw));
    chk("ramReadEnable", 32'(ramReadEnable), 32'(((ga || gb) && !gw) || rsp));
    chk("ramAddress", ramAddress, eaddr);
    if (ramWriteEnable) chk("ramWriteData", ramWriteData, ewd);
    chk("aRspValid", 32'(aRspValid), 32'(rsp && !pend_b));
    chk("bRspValid", 32'(bRspValid), 32'(rsp && pend_b));
    chk("rspData", rspData, rsp ? pend_d : 32'h0);
    if (use_tbl) begin
      chk("tbl_ready_rsp", 32'({aReady, bReady, aRspValid, bRspValid}), 32'(ef));
      chk("tbl_rspData", rspData, ed);
    end
    @(posedge clk);
    if (!rstN) begin
      pend_v = 0; last_b = 1; ref_addr = 0; ref_wd = 0;
    end else begin
      if ((ga || gb) && gw) ref_mem[eaddr[9:0]] = ewd;
      pend_v = (ga || gb) && !gw;
      pend_b = gb;
      if (pend_v) pend_d = ref_mem[eaddr[9:0]];
      if (ga) last_b = 0;
      if (gb) last_b = 1;
      ref_addr = eaddr; ref_wd = ewd;
    end
    m_ga = ga; m_gb = gb;
    #1;
  endtask

  typedef struct {
    logic av, aw; logic [31:0] aa, ad;
    logic bv, bw; logic [31:0] ba, bd;
    logic [3:0] ef; logic [31:0] ed;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic av, logic aw, logic [31:0] aa, logic [31:0] ad,
                              logic bv, logic bw, logic [31:0] ba, logic [31:0] bd,
                              logic [3:0] ef, logic [31:0] ed);
    mk = '{av, aw, aa, ad, bv, bw, ba, bd, ef, ed};
  endfunction

  function automatic logic [31:0] rnd_addr();
    rnd_addr = ($urandom_range(0, 7) == 0) ? 32'h3FF : 32'($urandom_range(0, 7));
  endfunction

  initial begin
    logic [31:0] pre_a [9] = '{0, 1, 2, 3, 4, 5, 6, 7, 32'h3FF};
    logic [31:0] pre_d [9] = '{32'h100, 32'h11, 32'h22, 32'h103, 32'h104, 32'h5A5A, 32'h106, 32'h107, 32'hCAFEF00D};
    // ef = {aReady, bReady, aRspValid, bRspValid}
    tbl.push_back(mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 32'hDEADBEEF));
`ifdef RAM_ARB_FIXED_PRIO_EN
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b1000, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b1010, 32'h11));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b1010, 32'h11));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b1010, 32'h11));
`else
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b0100, 0));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b1001, 32'h22));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b0110, 32'h11));
    tbl.push_back(mk(1, 0, 1, 0, 1, 0, 2, 0, 4'b1001, 32'h22));
`endif
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 32'h11));
    tbl.push_back(mk(1, 0, 5, 0, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 4'b0010, 32'h5A5A));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 4'b0100, 0));
    tbl.push_back(mk(1, 0, 32'h20, 0, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 32'h55));
    tbl.push_back(mk(1, 0, 32'h3FF, 0, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(1, 1, 0, 32'h1234, 0, 0, 0, 0, 4'b0010, 32'hCAFEF00D));
    tbl.push_back(mk(1, 1, 0, 32'h1234, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 32'h1234));
    tbl.push_back(mk(1, 0, 32'h3FF, 0, 0, 0, 0, 0, 4'b1000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010, 32'hCAFEF00D));

    // reset with requests pending: nothing may be granted or enabled
    rstN = 0; aValid = 1; aWrite = 1; bValid = 1;
    repeat (3) tick(1, 4'b0000, 0);
    rstN = 1; aValid = 0; aWrite = 0; bValid = 0;
    tick(1, 4'b0000, 0);

    // preload through port B
    bValid = 1; bWrite = 1;
    for (int i = 0; i < 9; i++) begin
      bAddr = pre_a[i]; bWData = pre_d[i];
      tick(1, 4'b0100, 0);
    end
    bValid = 0; bWrite = 0;

    foreach (tbl[i]) begin
      {aValid, aWrite, aAddr, aWData} = {tbl[i].av, tbl[i].aw, tbl[i].aa, tbl[i].ad};
      {bValid, bWrite, bAddr, bWData} = {tbl[i].bv, tbl[i].bw, tbl[i].ba, tbl[i].bd};
      tick(1, tbl[i].ef, tbl[i].ed);
    end

    // reset landing in RESP drops the response and leaves the block idle
    aValid = 1; aWrite = 0; aAddr = 1; bValid = 0;
    tick(1, 4'b1000, 0);
    rstN = 0; aAddr = 2;
    tick(1, 4'b0000, 0);
    tick(1, 4'b0000, 0);
    rstN = 1; aValid = 0;
    tick(1, 4'b0000, 0);
    aValid = 1; aWrite = 1; aAddr = 7; aWData = 32'h777;
    tick(1, 4'b1000, 0);
    aValid = 1; aWrite = 0;
    tick(1, 4'b1000, 0);
    aValid = 0;
    tick(1, 4'b0010, 32'h777);

    // random traffic; a refused request is held until accepted
    for (int n = 0; n < 400; n++) begin
      if (!(aValid && !m_ga)) begin
        aValid = $urandom_range(0, 2) != 0; aWrite = $urandom_range(0, 2) == 0;
        aAddr = rnd_addr(); aWData = $urandom;
      end
      if (!(bValid && !m_gb)) begin
        bValid = $urandom_range(0, 2) != 0; bWrite = $urandom_range(0, 2) == 0;
        bAddr = rnd_addr(); bWData = $urandom;
      end
      rstN = $urandom_range(0, 60) != 0;
      tick();
    end
    rstN = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
